// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - streaming KxK valid-mode convolution engine with serial weight load
// Optional ReLU on saturated results: define CONV_STREAM_RELU_EN.
module conv_stream_engine #(
    parameter int WIDTH       = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int FRAC_BITS   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        i_weight,
    input  logic                    i_weight_valid,
    input  logic                    i_weight_reload,
    input  logic [WIDTH-1:0]        i_pixel,
    input  logic                    i_pixel_valid,
    output logic                    o_pixel_ready,
    output logic [WIDTH-1:0]        o_feature,
    output logic                    o_feature_valid,
    input  logic                    i_feature_ready,
    output logic                    o_frame_done,
    output logic [1:0]              o_state
);
    localparam int K      = KERNEL_SIZE;
    localparam int N      = IMAGE_SIZE;
    localparam int KK     = K * K;
    localparam int WC_W   = $clog2(KK + 1);
    localparam int RC_W   = $clog2(N + 1);
    localparam int SR_LEN = (K - 1) * N + K - 1;
    localparam int ACC_W  = 2 * WIDTH + $clog2(KK);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_LOAD_WEIGHT = 2'd1;
    localparam logic [1:0] S_STREAM      = 2'd2;
    localparam logic [1:0] S_DONE        = 2'd3;

    logic [1:0]              state;
    logic signed [WIDTH-1:0] weights [KK];
    logic signed [WIDTH-1:0] taps [SR_LEN];
    logic signed [WIDTH-1:0] win [SR_LEN+1];
    logic [WC_W-1:0]         w_cnt;
    logic [RC_W-1:0]         row;
    logic [RC_W-1:0]         col;

    logic reload_ok, accept, last_col, last_row, win_ok, new_res;
    logic signed [2*WIDTH-1:0] op_w, op_p, prod;
    logic signed [ACC_W-1:0]   prod_ext, acc, acc_sh;
    logic [ACC_W-WIDTH:0]      hi;
    logic [WIDTH-1:0]          sat, result;

    assign reload_ok     = (state == S_STREAM) && (row == '0) && (col == '0) &&
                           !o_feature_valid && i_weight_reload;
    assign o_pixel_ready = (state == S_STREAM) && (!o_feature_valid || i_feature_ready) && !reload_ok;
    assign accept        = i_pixel_valid && o_pixel_ready;
    assign last_col      = (col == RC_W'(N - 1));
    assign last_row      = (row == RC_W'(N - 1));
    assign win_ok        = (row >= RC_W'(K - 1)) && (col >= RC_W'(K - 1));
    assign new_res       = accept && win_ok;
    assign o_state       = state;

    // win[0] is the pixel being accepted, win[n] the pixel accepted n beats earlier.
    always_comb begin
        win[0] = i_pixel;
        for (int n = 1; n <= SR_LEN; n++) begin
            win[n] = taps[n-1];
        end
    end

    always_comb begin
        acc      = '0;
        op_w     = '0;
        op_p     = '0;
        prod     = '0;
        prod_ext = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                op_w     = weights[i*K+j];
                op_p     = win[(K-1-i)*N + (K-1-j)];
                prod     = op_w * op_p;
                prod_ext = prod;
                acc      = acc + prod_ext;
            end
        end
        acc_sh = acc >>> FRAC_BITS;
        hi     = acc_sh[ACC_W-1:WIDTH-1];
        if ((&hi) || (~|hi)) begin
            sat = acc_sh[WIDTH-1:0];
        end else if (acc_sh[ACC_W-1]) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
`ifdef CONV_STREAM_RELU_EN
        result = sat[WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            w_cnt           <= '0;
            row             <= '0;
            col             <= '0;
            o_feature       <= '0;
            o_feature_valid <= 1'b0;
            o_frame_done    <= 1'b0;
            for (int n = 0; n < KK; n++) weights[n] <= '0;
            for (int n = 0; n < SR_LEN; n++) taps[n] <= '0;
        end else begin
            o_frame_done <= 1'b0;

            if (new_res) begin
                o_feature       <= result;
                o_feature_valid <= 1'b1;
            end else if (i_feature_ready) begin
                o_feature_valid <= 1'b0;
            end

            if (accept) begin
                taps[0] <= i_pixel;
                for (int n = 1; n < SR_LEN; n++) taps[n] <= taps[n-1];
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_weight_reload) begin
                        state <= S_LOAD_WEIGHT;
                        w_cnt <= '0;
                    end
                end
                S_LOAD_WEIGHT: begin
                    if (i_weight_valid) begin
                        weights[w_cnt] <= i_weight;
                        if (w_cnt == WC_W'(KK - 1)) begin
                            state <= S_STREAM;
                            w_cnt <= '0;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (reload_ok) begin
                        state <= S_LOAD_WEIGHT;
                        w_cnt <= '0;
                    end else if (accept && last_row && last_col) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    // Frame completes once the final result has left the output register.
                    if (!o_feature_valid || i_feature_ready) begin
                        state        <= S_STREAM;
                        o_frame_done <= 1'b1;
                        row          <= '0;
                        col          <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb/tb_conv_stream_engine.sv - self-checking bench for conv_stream_engine against a direct convolution model
module tb_conv_stream_engine;
    localparam int W  = 32;
    localparam int K  = 3;
    localparam int N  = 8;
    localparam int KK = K * K;
    localparam int NO = (N - K + 1) * (N - K + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] i_weight;
    logic         i_weight_valid;
    logic         i_weight_reload;
    logic [W-1:0] i_pixel;
    logic         i_pixel_valid;
    logic         o_pixel_ready;
    logic [W-1:0] o_feature;
    logic         o_feature_valid;
    logic         i_feature_ready;
    logic         o_frame_done;
    logic [1:0]   o_state;

    int tests = 0;
    int fails = 0;

    logic signed [W-1:0] wt [KK];
    logic signed [W-1:0] img [N*N];
    logic [W-1:0]        expq [$];

    conv_stream_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_weight        (i_weight),
        .i_weight_valid  (i_weight_valid),
        .i_weight_reload (i_weight_reload),
        .i_pixel         (i_pixel),
        .i_pixel_valid   (i_pixel_valid),
        .o_pixel_ready   (o_pixel_ready),
        .o_feature       (o_feature),
        .o_feature_valid (o_feature_valid),
        .i_feature_ready (i_feature_ready),
        .o_frame_done    (o_frame_done),
        .o_state         (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input int orow, input int ocol);
        logic signed [127:0] acc, pw, pp, mx, mn;
        acc = '0;
        mx  = 128'sh7FFF_FFFF;
        mn  = -128'sh8000_0000;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                pw  = wt[i*K+j];
                pp  = img[(orow+i)*N + ocol + j];
                acc = acc + pw * pp;
            end
        end
        if (acc > mx) acc = mx;
        else if (acc < mn) acc = mn;
`ifdef CONV_STREAM_RELU_EN
        if (acc < 0) acc = '0;
`endif
        return acc[W-1:0];
    endfunction

    task automatic load_weights();
        @(negedge clk);
        i_weight_reload = 1'b1;
        @(negedge clk);
        i_weight_reload = 1'b0;
        check("reload_enters_load", o_state, 2'd1);
        i_pixel_valid = 1'b1;
        #1;
        check("ready_low_in_load", o_pixel_ready, 1'b0);
        for (int k = 0; k < KK; k++) begin
            while ($urandom_range(0, 2) == 0) begin
                i_weight_valid = 1'b0;
                @(negedge clk);
            end
            i_weight_valid = 1'b1;
            i_weight       = wt[k];
            @(negedge clk);
        end
        i_weight_valid = 1'b0;
        i_pixel_valid  = 1'b0;
        check("load_to_stream", o_state, 2'd2);
    endtask

    // pix_mode: 0 always valid, 1 random. rdy_mode: 0 always ready, 1 random, 2 five-cycle stall after 10 outputs.
    task automatic run_frame(input int pix_mode, input int rdy_mode, input int reload_at,
                             output int first_v, output int acc22);
        int idx, got, c, budget, stall;
        logic held_v, acc_now, done_seen, exp_rdy;
        logic [W-1:0] held_f;
        expq.delete();
        for (int r = 0; r <= N - K; r++)
            for (int q = 0; q <= N - K; q++)
                expq.push_back(model(r, q));
        idx = 0; got = 0; c = 0; budget = 0; stall = 0;
        held_v = 1'b0; held_f = '0; done_seen = 1'b0;
        first_v = -1; acc22 = -1;
        while (budget < 3000) begin
            @(negedge clk);
            budget++;
            if (o_frame_done) begin
                check("done_after_last_output", (idx == N*N) && (got == NO), 1'b1);
                done_seen = 1'b1;
                break;
            end
            check("state_in_frame", o_state, (idx < N*N) ? 2'd2 : 2'd3);
            if (held_v) begin
                check("held_valid", o_feature_valid, 1'b1);
                check("held_data", o_feature, held_f);
            end
            if (o_feature_valid && first_v < 0) first_v = c;
            i_pixel_valid   = (idx < N*N) && (pix_mode == 0 || $urandom_range(0, 3) != 0);
            i_pixel         = (idx < N*N) ? img[idx] : '0;
            i_weight_reload = (reload_at >= 0) && (idx == reload_at);
            if (rdy_mode == 1) begin
                i_feature_ready = ($urandom_range(0, 2) != 0);
            end else if (rdy_mode == 2 && got == 10 && stall < 5) begin
                i_feature_ready = 1'b0;
                stall++;
            end else begin
                i_feature_ready = 1'b1;
            end
            #1;
            exp_rdy = (idx < N*N) && (!o_feature_valid || i_feature_ready);
            check("pixel_ready", o_pixel_ready, exp_rdy);
            if (o_feature_valid && i_feature_ready) begin
                if (expq.size() == 0) check("extra_output", 1'b1, 1'b0);
                else check("feature", o_feature, expq.pop_front());
                got++;
            end
            held_v  = o_feature_valid && !i_feature_ready;
            held_f  = o_feature;
            acc_now = i_pixel_valid && o_pixel_ready;
            @(posedge clk);
            c++;
            if (acc_now) begin
                if (idx == 2*N + 2) acc22 = c;
                idx++;
            end
        end
        i_pixel_valid   = 1'b0;
        i_weight_reload = 1'b0;
        i_feature_ready = 1'b1;
        check("frame_completed", done_seen, 1'b1);
        check("outputs_per_frame", got, NO);
        @(negedge clk);
        check("done_pulse_width", o_frame_done, 1'b0);
        check("back_to_stream", o_state, 2'd2);
    endtask

    initial begin
        int fv, a22;
        rst_n           = 1'b0;
        i_weight        = '0;
        i_weight_valid  = 1'b0;
        i_weight_reload = 1'b0;
        i_pixel         = '0;
        i_pixel_valid   = 1'b0;
        i_feature_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", o_state, 2'd0);
        check("rst_valid", o_feature_valid, 1'b0);
        check("rst_feature", o_feature, 0);
        check("rst_ready", o_pixel_ready, 1'b0);
        check("rst_done", o_frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        i_pixel_valid = 1'b1;
        @(negedge clk);
        #1;
        check("idle_refuses_pixels", o_pixel_ready, 1'b0);
        check("idle_stays_idle", o_state, 2'd0);
        i_pixel_valid = 1'b0;

        // Identity kernel on a ramp image: outputs are the interior pixels in order
        for (int k = 0; k < KK; k++) wt[k] = (k == 4) ? 1 : 0;
        for (int p = 0; p < N*N; p++) img[p] = p;
        load_weights();
        run_frame(0, 0, -1, fv, a22);
        check("first_valid_latency", fv, a22);

        for (int k = 0; k < KK; k++) wt[k] = 1;
        for (int p = 0; p < N*N; p++) img[p] = 1;
        load_weights();
        run_frame(0, 0, -1, fv, a22);
        run_frame(0, 0, -1, fv, a22);

        for (int k = 0; k < KK; k++) wt[k] = (k == 4) ? 1 : 0;
        for (int p = 0; p < N*N; p++) img[p] = p;
        load_weights();
        run_frame(0, 2, -1, fv, a22);

        for (int k = 0; k < KK; k++) wt[k] = int'($urandom_range(0, 200)) - 100;
        for (int p = 0; p < N*N; p++) img[p] = int'($urandom_range(0, 2000)) - 1000;
        load_weights();
        run_frame(1, 1, -1, fv, a22);
        for (int p = 0; p < N*N; p++) img[p] = int'($urandom_range(0, 2000)) - 1000;
        run_frame(1, 1, 30, fv, a22);

        for (int k = 0; k < KK; k++) wt[k] = 1;
        load_weights();
        for (int p = 0; p < N*N; p++) img[p] = 32'h7FFF_FFFF;
        run_frame(0, 0, -1, fv, a22);
        for (int p = 0; p < N*N; p++) img[p] = 32'h8000_0000;
        run_frame(1, 1, -1, fv, a22);

        // Reset after 20 pixels discards the frame and returns to IDLE
        for (int k = 0; k < KK; k++) wt[k] = (k == 4) ? 1 : 0;
        for (int p = 0; p < N*N; p++) img[p] = p;
        load_weights();
        for (int p = 0; p < 20; p++) begin
            @(negedge clk);
            i_pixel       = img[p];
            i_pixel_valid = 1'b1;
        end
        @(negedge clk);
        i_pixel_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_state", o_state, 2'd0);
        check("midrst_valid", o_feature_valid, 1'b0);
        check("midrst_feature", o_feature, 0);
        check("midrst_ready", o_pixel_ready, 1'b0);
        check("midrst_done", o_frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        i_pixel_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_refuse", o_pixel_ready, 1'b0);
            check("post_rst_idle", o_state, 2'd0);
        end
        i_pixel_valid = 1'b0;

        for (int k = 0; k < KK; k++) wt[k] = int'($urandom_range(0, 200)) - 100;
        for (int p = 0; p < N*N; p++) img[p] = int'($urandom_range(0, 2000)) - 1000;
        load_weights();
        run_frame(1, 1, -1, fv, a22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Parametrised successor to the fixed 8x8 / 3x3 / 6-kernel convolution layer.
- Accepts a row-major pixel stream over a valid/ready handshake and holds the last KERNEL_SIZE-1 image rows in line buffers.
- Forms a KERNEL_SIZE x KERNEL_SIZE sliding window and emits one valid-mode (no padding) convolution result per output position, with backpressure.
- Weights are loaded serially per frame group and retained across frames until reloaded.

Parameters:
WIDTH, 32, signed pixel/weight/output width
KERNEL_SIZE, 3, kernel edge length K
IMAGE_SIZE, 8, image edge length N (square image)
FRAC_BITS, 0, arithmetic right shift applied to accumulator before saturation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_weight  input  WIDTH  signed weight word
i_weight_valid  input  1  weight word present
i_weight_reload  input  1  one-cycle pulse requesting a new weight load
i_pixel  input  WIDTH  signed pixel word
i_pixel_valid  input  1  pixel word present
o_pixel_ready  output  1  engine accepts pixel this cycle
o_feature  output  WIDTH  signed convolution result
o_feature_valid  output  1  o_feature holds a result
i_feature_ready  input  1  downstream accepts result
o_frame_done  output  1  one-cycle pulse after the last output of a frame is accepted
o_state  output  2  current FSM state, for debug

Behaviour:
- Reset: state IDLE; all outputs 0; weights, line buffers, window and counters cleared. Reset mid-frame discards the frame; weights must be reloaded.
- FSM encoding: IDLE=0, LOAD_WEIGHT=1, STREAM=2, DONE=3.
- IDLE -> LOAD_WEIGHT on i_weight_reload.
- LOAD_WEIGHT:
  - Each cycle with i_weight_valid stores i_weight at index w_cnt (row-major, index 0 = top-left); o_pixel_ready=0.
  - After K*K words, go to STREAM with row=col=0.
- STREAM:
  - o_pixel_ready = !o_feature_valid || i_feature_ready.
  - Accept = i_pixel_valid && o_pixel_ready.
  - On accept at position (r,c): shift the window, write the line buffers, advance col; col wraps N-1 -> 0 and increments row.
- Window mapping: weight index i*K+j multiplies pixel (r-K+1+i, c-K+1+j).
- Result generation:
  - A result is produced only when r>=K-1 and c>=K-1. It is output (r-K+1, c-K+1).
  - Latency: o_feature_valid rises on the cycle after the accepting edge.
  - o_feature_valid and o_feature are held stable until i_feature_ready.
  - Simultaneous new result and consumption: replace the result in the same cycle, valid stays 1.
  - Consumption with no new result: valid clears.
- Outputs per frame: (N-K+1)^2, i.e. 36 for 8/3.
- Arithmetic:
  - Each product is a 2*WIDTH signed value.
  - Sum into an accumulator of 2*WIDTH+clog2(K*K) bits, then arithmetic shift right by FRAC_BITS.
  - Saturate to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- End of frame:
  - After pixel (N-1,N-1) is accepted, go to DONE; o_pixel_ready=0.
  - Wait until the final result is consumed, then pulse o_frame_done for one cycle and return to STREAM with row=col=0. Weights are kept.
- Reload:
  - i_weight_reload is honoured in STREAM only when row=col=0 and no result is pending; it goes to LOAD_WEIGHT.
  - Mid-frame, or in LOAD_WEIGHT or DONE, it is ignored.
  - i_weight_valid outside LOAD_WEIGHT is ignored.
- i_pixel_valid outside STREAM: no accept, no effect.

Optional Feature:
- Macro CONV_STREAM_RELU_EN.
- Defined: saturated results below 0 are output as 0 (ReLU), applied after saturation.
- Undefined: signed saturated result is passed unchanged.
- Handshake and timing are identical either way.

Test Plan:
- Identity kernel (weight 4=1, others 0), pixel(r,c)=8r+c, i_feature_ready=1:
  - 36 outputs 9,10,...,14,17,...,54 in order; first o_feature_valid the cycle after pixel (2,2) accepted.
  - o_frame_done pulses once.
- All-ones kernel, all-ones image: 36 outputs each 9; second back-to-back frame without reload also yields 36 nines.
- Backpressure: i_feature_ready=0 for 5 cycles mid-frame:
  - o_pixel_ready=0 throughout; o_feature stable.
  - No pixel lost; output sequence identical to the unstalled run.
- Saturation: all weights 1, all pixels 0x7FFFFFFF -> o_feature 0x7FFFFFFF.
- Negative saturation: pixels 0x80000000 -> 0x80000000 without macro; 0 with CONV_STREAM_RELU_EN.
- Reset and reload:
  - rst_n low after 20 pixels -> all outputs 0, o_state=0, and pixels are refused until reload.
  - i_weight_reload asserted mid-frame is ignored; asserted between frames it enters LOAD_WEIGHT and new weights take effect on the next frame.
